i2s2_axil_regbank: RTL and testbench

//  Parametrised AXI4-Lite slave register bank; successor to the fixed 4 x 32-bit S00_AXI slave in the i2s2 IP.

---
 rtl/i2s2_axil_pkg.sv | 20 ++
 rtl/i2s2_axil_wr_hold.sv | 35 +++
 rtl/i2s2_axil_regbank.sv | 157 +++++++++++++++
 tb/tb_i2s2_axil_regbank.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s2_axil_pkg.sv
// Shared response codes, register indices and address helper for the i2s2 AXI4-Lite register bank.
package i2s2_axil_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    localparam int REG_CTRL   = 0;
    localparam int REG_STAT   = 3;
    localparam int REG_IRQ_EN = 4;

    // Number of byte-offset address bits below the register index.
    function automatic int addr_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/i2s2_axil_wr_hold.sv
// Single-entry holding register for one AXI write channel; ready whenever the slot is empty.
// A beat consumed in its arrival cycle bypasses the slot, so back-to-back beats flow at full rate.
module i2s2_axil_wr_hold #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid,
    input  logic [W-1:0] data,
    output logic         ready,
    output logic         avail,
    output logic [W-1:0] q,
    input  logic         consume
);

    logic         full;
    logic [W-1:0] data_r;

    assign ready = !full;
    assign avail = full || valid;
    assign q     = full ? data_r : data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full   <= 1'b0;
            data_r <= '0;
        end else if (consume) begin
            full <= 1'b0;
        end else if (valid && !full) begin
            full   <= 1'b1;
            data_r <= data;
        end
    end

endmodule

// File: rtl/i2s2_axil_regbank.sv
// AXI4-Lite register bank with byte strobes, RO and W1C registers, write pulses and a level irq.
// Writes respond 1 cycle after AW and W are both present; reads return 1 cycle after AR; one read outstanding.
module i2s2_axil_regbank
    import i2s2_axil_pkg::*;
#(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 6,
    parameter int          NUM_REGS           = 8,
    parameter logic [15:0] RO_MASK            = 16'h0004,
    parameter int          STAT_IDX           = REG_STAT,
    parameter int          IRQ_EN_IDX         = REG_IRQ_EN
) (
    input  logic                                   S_AXI_ACLK,
    input  logic                                   S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                             S_AXI_AWPROT,
    input  logic                                   S_AXI_AWVALID,
    output logic                                   S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                                   S_AXI_WVALID,
    output logic                                   S_AXI_WREADY,
    output logic [1:0]                             S_AXI_BRESP,
    output logic                                   S_AXI_BVALID,
    input  logic                                   S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                             S_AXI_ARPROT,
    input  logic                                   S_AXI_ARVALID,
    output logic                                   S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                             S_AXI_RRESP,
    output logic                                   S_AXI_RVALID,
    input  logic                                   S_AXI_RREADY,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] ro_in,
    output logic [NUM_REGS-1:0]                    wr_pulse,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          irq_set,
    output logic                                   irq
);

    localparam int DW   = C_S_AXI_DATA_WIDTH;
    localparam int SW   = DW / 8;
    localparam int ALSB = addr_lsb(DW);
    localparam int IW   = C_S_AXI_ADDR_WIDTH - ALSB;

    logic [DW-1:0]                 regs [NUM_REGS];
    logic                          aw_avail, w_avail, commit, wr_en;
    logic [C_S_AXI_ADDR_WIDTH-1:0] aw_q;
    logic [DW+SW-1:0]              w_q;
    logic [DW-1:0]                 w_data, w_mask, r_val, rdata_q;
    logic [SW-1:0]                 w_strb;
    logic [NUM_REGS-1:0]           w_sel;
    resp_t                         w_resp, r_resp, bresp_q, rresp_q;
    logic                          bvalid, rvalid;
    logic                          unused_bits;

    i2s2_axil_wr_hold #(.W(C_S_AXI_ADDR_WIDTH)) u_aw_hold (
        .clk(S_AXI_ACLK), .rst(S_AXI_ARESET),
        .valid(S_AXI_AWVALID), .data(S_AXI_AWADDR), .ready(S_AXI_AWREADY),
        .avail(aw_avail), .q(aw_q), .consume(commit)
    );

    i2s2_axil_wr_hold #(.W(DW + SW)) u_w_hold (
        .clk(S_AXI_ACLK), .rst(S_AXI_ARESET),
        .valid(S_AXI_WVALID), .data({S_AXI_WSTRB, S_AXI_WDATA}), .ready(S_AXI_WREADY),
        .avail(w_avail), .q(w_q), .consume(commit)
    );

    assign {w_strb, w_data} = w_q;
    assign commit = aw_avail && w_avail && (!bvalid || S_AXI_BREADY);
    assign wr_en  = commit && (w_resp == RESP_OKAY);

    always_comb begin
        w_mask = '0;
        for (int k = 0; k < SW; k++) w_mask[k*8 +: 8] = {8{w_strb[k]}};
    end

    // One-hot register select; all-zero means the index is past the end of the bank.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) w_sel[i] = (aw_q[ALSB +: IW] == IW'(i));
    end

    always_comb begin
        w_resp = RESP_OKAY;
        if (w_sel == '0)                                 w_resp = RESP_DECERR;
        else if ((w_sel & RO_MASK[NUM_REGS-1:0]) != '0)  w_resp = RESP_SLVERR;
    end

    always_comb begin
        r_val  = '0;
        r_resp = RESP_DECERR;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (S_AXI_ARADDR[ALSB +: IW] == IW'(i)) begin
                r_resp = RESP_OKAY;
                r_val  = RO_MASK[i] ? ro_in[i*DW +: DW] : regs[i];
            end
        end
    end

    // Status bits are set by hardware every cycle; a simultaneous W1C loses to the set.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            bvalid   <= 1'b0;
            bresp_q  <= RESP_OKAY;
            wr_pulse <= '0;
        end else begin
            wr_pulse <= wr_en ? w_sel : '0;
            if (commit) begin
                bvalid  <= 1'b1;
                bresp_q <= w_resp;
            end else if (S_AXI_BREADY) begin
                bvalid <= 1'b0;
            end
            for (int i = 0; i < NUM_REGS; i++) begin
                if (i == STAT_IDX)
                    regs[i] <= (regs[i] & ~((wr_en && w_sel[i]) ? (w_data & w_mask) : '0)) | irq_set;
                else if (wr_en && w_sel[i])
                    regs[i] <= (regs[i] & ~w_mask) | (w_data & w_mask);
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            rvalid  <= 1'b0;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (S_AXI_ARVALID && !rvalid) begin
            rvalid  <= 1'b1;
            rdata_q <= r_val;
            rresp_q <= r_resp;
        end else if (rvalid && S_AXI_RREADY) begin
            rvalid <= 1'b0;
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) irq <= 1'b0;
        else              irq <= |(regs[STAT_IDX] & regs[IRQ_EN_IDX]);
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign reg_out[g*DW +: DW] = regs[g];
    end

    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = !rvalid;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, aw_q[ALSB-1:0], S_AXI_ARADDR[ALSB-1:0], ro_in};

endmodule

// File: tb/tb_i2s2_axil_regbank.sv
// Scoreboard bench for i2s2_axil_regbank: stimulus pushes model responses, a negedge monitor checks them.
module tb_i2s2_axil_regbank;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int NR = 8;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  r;
    } rexp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [AW-1:0]     AWADDR, ARADDR;
    logic [2:0]        AWPROT, ARPROT;
    logic              AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic              ARVALID, ARREADY, RVALID, RREADY;
    logic [DW-1:0]     WDATA, RDATA, irq_set;
    logic [DW/8-1:0]   WSTRB;
    logic [1:0]        BRESP, RRESP;
    logic [NR*DW-1:0]  reg_out, ro_in;
    logic [NR-1:0]     wr_pulse;
    logic              irq;

    int total = 0;
    int bad   = 0;
    int b_issued = 0, b_seen = 0, r_issued = 0, r_seen = 0;
    int exp_pulse [NR];
    int pulse_cnt [NR];
    logic [31:0] m [16];
    logic [31:0] ro_val;
    logic [1:0]  bq [$];
    rexp_t       rq [$];
    bit          b_hold = 0, r_hold = 0, rand_rdy = 0;

    i2s2_axil_regbank dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(AWPROT), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
        .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
        .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
        .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(ARPROT), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
        .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY),
        .reg_out(reg_out), .ro_in(ro_in), .wr_pulse(wr_pulse), .irq_set(irq_set), .irq(irq)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: register file semantics computed straight from the register rules.
    function automatic logic [1:0] model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] mk;
        for (int k = 0; k < 4; k++) mk[k*8 +: 8] = {8{s[k]}};
        if (idx >= NR) return 2'b11;
        if (idx == 2)  return 2'b10;
        if (idx == 3) m[3] = m[3] & ~(d & mk);
        else          m[idx] = (m[idx] & ~mk) | (d & mk);
        exp_pulse[idx]++;
        return 2'b00;
    endfunction

    function automatic rexp_t model_read(input int idx);
        rexp_t e;
        if (idx >= NR)     begin e.d = 32'h0;  e.r = 2'b11; end
        else if (idx == 2) begin e.d = ro_val; e.r = 2'b00; end
        else               begin e.d = m[idx]; e.r = 2'b00; end
        return e;
    endfunction

    // Ready generator runs 2 time units after the edge so stimulus flags set at +1 take effect the same cycle.
    initial begin
        BREADY = 1'b1;
        RREADY = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            BREADY = b_hold ? 1'b0 : (rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
            RREADY = r_hold ? 1'b0 : (rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    end

    initial forever begin
        @(negedge clk);
        if (BVALID && BREADY) begin
            if (bq.size() == 0) begin
                total++; bad++;
                $display("FAIL b_unexpected: got bresp 0x%0h with no write outstanding", BRESP);
            end else begin
                chk("bresp", 64'(BRESP), 64'(bq.pop_front()));
            end
            b_seen++;
        end
        if (RVALID && RREADY) begin
            if (rq.size() == 0) begin
                total++; bad++;
                $display("FAIL r_unexpected: got rdata 0x%0h with no read outstanding", RDATA);
            end else begin
                rexp_t e;
                e = rq.pop_front();
                chk("rdata", 64'(RDATA), 64'(e.d));
                chk("rresp", 64'(RRESP), 64'(e.r));
            end
            r_seen++;
        end
        for (int i = 0; i < NR; i++) if (wr_pulse[i]) pulse_cnt[i]++;
    end

    task automatic wait_b();
        int n = 0;
        while (b_seen < b_issued && n < 200) begin @(posedge clk); #1; n++; end
        chk("b_timeout", 64'(b_seen < b_issued), 64'(0));
    endtask

    task automatic wait_r();
        int n = 0;
        while (r_seen < r_issued && n < 200) begin @(posedge clk); #1; n++; end
        chk("r_timeout", 64'(r_seen < r_issued), 64'(0));
    endtask

    task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input bit wait_resp);
        int n = 0;
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        bq.push_back(model_write(int'(a[5:2]), d, s));
        b_issued++;
        AWADDR = a; WDATA = d; WSTRB = s;
        while (!(aw_done && w_done) && n < 100) begin
            if (!aw_done && n >= aw_dly) AWVALID = 1'b1;
            if (!w_done && n >= w_dly)   WVALID  = 1'b1;
            @(negedge clk);
            aw_hs = AWVALID && AWREADY;
            w_hs  = WVALID && WREADY;
            @(posedge clk); #1;
            if (aw_hs) begin AWVALID = 1'b0; aw_done = 1; end
            if (w_hs)  begin WVALID  = 1'b0; w_done  = 1; end
            n++;
        end
        chk("aw_w_accept_timeout", 64'(aw_done && w_done), 64'(1));
        if (wait_resp) wait_b();
    endtask

    task automatic do_read(input logic [5:0] a, input int ar_dly, input bit wait_resp);
        int n = 0;
        bit done = 0, hs;
        rq.push_back(model_read(int'(a[5:2])));
        r_issued++;
        ARADDR = a;
        while (!done && n < 100) begin
            if (n >= ar_dly) ARVALID = 1'b1;
            @(negedge clk);
            hs = ARVALID && ARREADY;
            @(posedge clk); #1;
            if (hs) begin ARVALID = 1'b0; done = 1; end
            n++;
        end
        chk("ar_accept_timeout", 64'(done), 64'(1));
        if (wait_resp) wait_r();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_awready"}, 64'(AWREADY), 64'(1));
        chk({tag, "_wready"},  64'(WREADY),  64'(1));
        chk({tag, "_arready"}, 64'(ARREADY), 64'(1));
        chk({tag, "_bvalid"},  64'(BVALID),  64'(0));
        chk({tag, "_rvalid"},  64'(RVALID),  64'(0));
        chk({tag, "_bresp"},   64'(BRESP),   64'(0));
        chk({tag, "_rresp"},   64'(RRESP),   64'(0));
        chk({tag, "_rdata"},   64'(RDATA),   64'(0));
        chk({tag, "_wr_pulse"}, 64'(wr_pulse), 64'(0));
        chk({tag, "_irq"},     64'(irq),     64'(0));
        chk({tag, "_reg_out"}, 64'(|reg_out), 64'(0));
    endtask

    initial begin
        rst = 1'b1;
        AWADDR = '0; ARADDR = '0; AWPROT = '0; ARPROT = '0;
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        WDATA = '0; WSTRB = '0; irq_set = '0;
        ro_val = 32'h0000_CAFE;
        for (int i = 0; i < 16; i++) m[i] = '0;
        for (int i = 0; i < NR; i++) begin
            exp_pulse[i] = 0;
            pulse_cnt[i] = 0;
            ro_in[i*DW +: DW] = (i == 2) ? ro_val : $urandom;
        end
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Write 1..8 to every writable register, read all back, count write pulses.
        for (int i = 0; i < NR; i++)
            if (i != 2) do_write(6'(i * 4), 32'(i + 1), 4'hF, 0, 0, 1);
        for (int i = 0; i < NR; i++) do_read(6'(i * 4), 0, 1);
        for (int i = 0; i < NR; i++) chk($sformatf("t1_pulse_cnt%0d", i), 64'(pulse_cnt[i]), 64'(exp_pulse[i]));

        // W three cycles ahead of AW, then AW and W together; B held off for 5 cycles each time.
        b_hold = 1;
        do_write(6'h14, 32'hA5A5_0001, 4'hF, 3, 0, 0);
        for (int c = 0; c < 5; c++) begin
            chk("t2_bvalid_held_w_first", 64'(BVALID), 64'(1));
            @(posedge clk); #1;
        end
        b_hold = 0;
        wait_b();
        b_hold = 1;
        do_write(6'h14, 32'h5A5A_0002, 4'hF, 0, 0, 0);
        for (int c = 0; c < 5; c++) begin
            chk("t2_bvalid_held_same", 64'(BVALID), 64'(1));
            @(posedge clk); #1;
        end
        b_hold = 0;
        wait_b();
        do_read(6'h14, 0, 1);
        chk("t2_pulse_cnt5", 64'(pulse_cnt[5]), 64'(exp_pulse[5]));

        // Byte strobes.
        do_write(6'h00, 32'h0, 4'hF, 0, 0, 1);
        do_write(6'h00, 32'hFFFF_FFFF, 4'b0101, 0, 1, 1);
        chk("t3_reg_out0", 64'(reg_out[31:0]), 64'h00FF_00FF);
        do_read(6'h00, 0, 1);

        // Read-only and out-of-range accesses.
        do_write(6'h08, 32'h1234_5678, 4'hF, 0, 0, 1);
        do_read(6'h08, 0, 1);
        do_write(6'h3C, 32'hDEAD_BEEF, 4'hF, 0, 0, 1);
        do_read(6'h3C, 1, 1);

        // Interrupt set, set-wins-over-clear, then clear.
        do_write(6'h10, 32'h1, 4'hF, 0, 0, 1);
        chk("t5_irq_idle", 64'(irq), 64'(|(m[3] & m[4])));
        irq_set = 32'h1;
        @(posedge clk); #1;
        irq_set = 32'h0;
        m[3] = m[3] | 32'h1;
        chk("t5_irq_lag", 64'(irq), 64'(0));
        @(posedge clk); #1;
        chk("t5_irq_set", 64'(irq), 64'(|(m[3] & m[4])));
        AWADDR = 6'h0C; WDATA = 32'h1; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1; irq_set = 32'h1;
        bq.push_back(model_write(3, 32'h1, 4'hF));
        b_issued++;
        m[3] = m[3] | 32'h1;
        @(posedge clk); #1;
        AWVALID = 1'b0; WVALID = 1'b0; irq_set = 32'h0;
        wait_b();
        chk("t5_irq_set_wins", 64'(irq), 64'(|(m[3] & m[4])));
        do_read(6'h0C, 0, 1);
        do_write(6'h0C, 32'h1, 4'hF, 0, 0, 1);
        @(posedge clk); #1;
        chk("t5_irq_cleared", 64'(irq), 64'(|(m[3] & m[4])));

        // Read and write of the same register in one cycle: read sees the old value.
        rq.push_back(model_read(6));
        r_issued++;
        bq.push_back(model_write(6, 32'h6666_0066, 4'hF));
        b_issued++;
        AWADDR = 6'h18; ARADDR = 6'h18; WDATA = 32'h6666_0066; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
        @(posedge clk); #1;
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        wait_b();
        wait_r();
        do_read(6'h18, 0, 1);

        // Randomized traffic with random handshake delays and random ready throttling.
        rand_rdy = 1;
        for (int t = 0; t < 150; t++) begin
            logic [5:0] a;
            a = 6'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), 1);
            else
                do_read(a, $urandom_range(0, 2), 1);
        end
        rand_rdy = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++)
            if (i != 2) chk($sformatf("rand_reg_out%0d", i), 64'(reg_out[i*DW +: DW]), 64'(m[i]));

        // Reset with an AW held in the bank and a read response pending.
        AWADDR = 6'h04; AWVALID = 1'b1;
        @(posedge clk); #1;
        AWVALID = 1'b0;
        chk("t6_aw_held", 64'(AWREADY), 64'(0));
        r_hold = 1;
        do_read(6'h04, 0, 0);
        chk("t6_rvalid_pending", 64'(RVALID), 64'(1));
        rst = 1'b1;
        #1;
        chk_reset_outputs("t6_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        rq.delete();
        r_issued = r_seen;
        r_hold = 0;
        for (int i = 0; i < 16; i++) m[i] = '0;
        @(posedge clk); #1;
        do_write(6'h18, 32'h1357_9BDF, 4'hF, 1, 0, 1);
        do_read(6'h18, 0, 1);
        do_read(6'h04, 0, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("end_bq_drained", 64'(bq.size()), 64'(0));
        chk("end_rq_drained", 64'(rq.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
